// File: rtl/warp_scheduler_pkg.sv
// Shared types and constants for the warp scheduler slice.
//   scheduler_state_t : top-level scheduler FSM state (idle / running a block)
package warp_scheduler_pkg;

  typedef enum logic [0:0] {
    SCHED_IDLE,
    SCHED_RUN
  } scheduler_state_t;

  // Default number of warps resident on one core.
  localparam int DEFAULT_WARPS_PER_CORE = 4;

endpackage : warp_scheduler_pkg

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr+1 and wrapping modulo N. The first set bit wins.
// N must be a power of two, so ptr arithmetic wraps naturally.
//   req       in   N     request vector
//   ptr       in   IW    index of the last winner (highest priority goes to ptr+1)
//   gnt_valid out  1     any request present
//   gnt_idx   out  IW    winning index (0 when gnt_valid=0)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;

  // Walk offsets 1..N. Offset N truncates to 0, so ptr itself is the last candidate.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ptr + IW'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler.
// It tracks the live warps of the resident block. Each cycle it grants one
// ready warp to the shared execute datapath using round-robin order. It pulses
// done when the last live warp finishes.
//   clk              in   1       core clock
//   reset            in   1       asynchronous active-low reset
//   start            in   1       launch pulse (honoured only while idle)
//   num_active_warps in   WIDX+1  warps used by the block, saturated to W
//   warp_ready       in   W       per-warp ready to issue
//   warp_finish      in   W       per-warp Finish retired this cycle
//   issue_en         in   1       datapath accepts an issue this cycle
//   issue_valid      out  1       a warp is granted this cycle
//   current_warp     out  WIDX    granted warp (0 when no grant)
//   warp_active      out  W       registered live-warp mask
//   done             out  1       pulse in the cycle the block completes
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter  int WARPS_PER_CORE = DEFAULT_WARPS_PER_CORE,
  localparam int WIDX           = $clog2(WARPS_PER_CORE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDX:0]             num_active_warps,
  input  logic [WARPS_PER_CORE-1:0] warp_ready,
  input  logic [WARPS_PER_CORE-1:0] warp_finish,
  input  logic                      issue_en,
  output logic                      issue_valid,
  output logic [WIDX-1:0]           current_warp,
  output logic [WARPS_PER_CORE-1:0] warp_active,
  output logic                      done
);

  localparam int W = WARPS_PER_CORE;
  localparam logic [WIDX-1:0] PTR_LAST = WIDX'(W - 1);

  scheduler_state_t state_reg, state_next;
  logic [W-1:0]     warp_active_reg, warp_active_next;
  logic [WIDX-1:0]  rr_ptr_reg, rr_ptr_next;

  logic [W-1:0]     launch_mask;
  logic [W-1:0]     remaining;
  logic [W-1:0]     eligible;
  logic             gnt_valid;
  logic [WIDX-1:0]  gnt_idx;

  // Thermometer mask of the first n warps. Requests above W set every bit,
  // so the saturation to W needs no extra logic.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_launch
      assign launch_mask[gi] = (num_active_warps > (WIDX + 1)'(gi));
    end
  endgenerate

  // A warp retiring Finish this cycle is neither live next cycle nor grantable now.
  assign remaining = warp_active_reg & ~warp_finish;
  assign eligible  = (state_reg == SCHED_RUN) ? (remaining & warp_ready) : '0;

  rr_arbiter #(.N(W)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign issue_valid  = gnt_valid;
  assign current_warp = gnt_idx;
  assign warp_active  = warp_active_reg;

  always_comb begin
    state_next       = state_reg;
    warp_active_next = warp_active_reg;
    rr_ptr_next      = rr_ptr_reg;
    done             = 1'b0;
    case (state_reg)
      SCHED_IDLE: begin
        if (start) begin
          if (launch_mask == '0) begin
            // An empty block completes in the launch cycle itself.
            done = 1'b1;
          end else begin
            state_next       = SCHED_RUN;
            warp_active_next = launch_mask;
            rr_ptr_next      = PTR_LAST;
          end
        end
      end
      SCHED_RUN: begin
        warp_active_next = remaining;
        // The pointer moves only on an accepted issue, so a stalled grant stays put.
        if (gnt_valid && issue_en) begin
          rr_ptr_next = gnt_idx;
        end
        // Early done: raised while the last finish is still in flight.
        if (remaining == '0) begin
          done       = 1'b1;
          state_next = SCHED_IDLE;
        end
      end
      default: begin
        state_next = SCHED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= SCHED_IDLE;
      warp_active_reg <= '0;
      rr_ptr_reg      <= PTR_LAST;
    end else begin
      state_reg       <= state_next;
      warp_active_reg <= warp_active_next;
      rr_ptr_reg      <= rr_ptr_next;
    end
  end

endmodule : warp_scheduler
